// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the byte-wide instruction fetch controller.
// Instructions are big-endian: the byte at the lowest address is bits 31:24.
package imem_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    LOAD  = 2'd2
  } state_e;

  localparam int INSTR_BYTES = 4;

  // Left shift that places byte idx of a word at its big-endian position.
  function automatic logic [4:0] byte_shift(input logic [1:0] idx);
    return {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/imem_byte_assembler.sv
// Collects four returned memory bytes into one big-endian instruction word.
// done_o flags the cycle the last byte arrives; word_o already includes it.
module imem_byte_assembler
  import imem_fetch_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        capture_i,
  input  logic [7:0]  byte_i,
  output logic        done_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] merged;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    merged = asm_q | (32'(byte_i) << byte_shift(cnt_q));
    done_o = capture_i && (cnt_q == 2'(INSTR_BYTES - 1));
    word_o = merged;
    if (clear_i || done_o) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (capture_i) begin
      cnt_d = cnt_q + 2'd1;
      asm_d = merged;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst_i) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a byte-wide single-port instruction memory with a loader port.
// Define IFETCH_MISALIGN_CHK_EN to trap misaligned redirects on fetch_fault_o.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [31:0]       instr_code_o,
  output logic [31:0]       instr_pc_o,
  input  logic              load_req_i,
  input  logic              load_valid_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_data_i,
  output logic              load_busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              mem_wr_en_o,
  output logic [7:0]        mem_wdata_o,
  output logic              fetch_fault_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issue_q, issue_d;
  logic        rd_pend_q, rd_pend_d;
  logic        valid_q, valid_d;
  logic [31:0] code_q, code_d;
  logic [31:0] ipc_q, ipc_d;
  logic        busy_q, busy_d;
  logic        asm_clear, asm_done;
  logic [31:0] asm_word;
  logic        misalign;

  imem_byte_assembler u_asm (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (asm_clear),
    .capture_i (rd_pend_q),
    .byte_i    (mem_rdata_i),
    .done_o    (asm_done),
    .word_o    (asm_word)
  );

`ifdef IFETCH_MISALIGN_CHK_EN
  logic fault_q;
  assign misalign = (redirect_pc_i[1:0] != 2'b00);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_q <= 1'b0;
    end else if (state_q != LOAD && !load_req_i && redirect_valid_i && misalign) begin
      fault_q <= 1'b1;
    end
  end
  assign fetch_fault_o = fault_q;
`else
  assign misalign      = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  // Memory port is combinational so issue k appears in the same cycle the counter holds k.
  always_comb begin
    mem_addr_o  = pc_q[ADDR_W-1:0] + ADDR_W'(issue_q);
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_wdata_o = load_data_i;
    if (!rst_i) begin
      unique case (state_q)
        FETCH: mem_rd_en_o = (issue_q < 3'(INSTR_BYTES));
        LOAD: begin
          mem_addr_o  = load_addr_i;
          mem_wr_en_o = load_valid_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    issue_d   = issue_q;
    rd_pend_d = mem_rd_en_o;
    valid_d   = valid_q;
    code_d    = code_q;
    ipc_d     = ipc_q;
    busy_d    = busy_q;
    asm_clear = 1'b0;
    unique case (state_q)
      FETCH, HOLD: begin
        if (load_req_i) begin
          state_d   = LOAD;
          valid_d   = 1'b0;
          busy_d    = 1'b1;
          issue_d   = '0;
          rd_pend_d = 1'b0;
          asm_clear = 1'b1;
        end else if (redirect_valid_i) begin
          // In-flight bytes are dropped: clearing rd_pend stops the stale return being captured.
          valid_d   = 1'b0;
          issue_d   = '0;
          rd_pend_d = 1'b0;
          asm_clear = 1'b1;
          if (misalign) begin
            state_d = HOLD;
          end else begin
            pc_d    = redirect_pc_i;
            state_d = FETCH;
          end
        end else if (state_q == FETCH) begin
          if (mem_rd_en_o) begin
            issue_d = issue_q + 3'd1;
          end
          if (asm_done) begin
            code_d  = asm_word;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            issue_d = '0;
            state_d = HOLD;
          end
        end else if (valid_q && instr_ready_i) begin
          valid_d = 1'b0;
          pc_d    = pc_q + 32'd4;
          issue_d = '0;
          state_d = FETCH;
        end
      end
      LOAD: begin
        if (!load_req_i) begin
          state_d = FETCH;
          pc_d    = RESET_PC;
          busy_d  = 1'b0;
          issue_d = '0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      issue_q   <= '0;
      rd_pend_q <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      ipc_q     <= RESET_PC;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      issue_q   <= issue_d;
      rd_pend_q <= rd_pend_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      ipc_q     <= ipc_d;
      busy_q    <= busy_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_code_o  = code_q;
  assign instr_pc_o    = ipc_q;
  assign load_busy_o   = busy_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-timeline reference model.
module tb_imem_fetch_ctrl;

  localparam int          ADDR_W   = 11;
  localparam int          MEM_SZ   = 1 << ADDR_W;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              redirect_valid_i = 1'b0;
  logic [31:0]       redirect_pc_i = '0;
  logic              instr_valid_o;
  logic              instr_ready_i = 1'b1;
  logic [31:0]       instr_code_o;
  logic [31:0]       instr_pc_o;
  logic              load_req_i = 1'b0;
  logic              load_valid_i = 1'b0;
  logic [ADDR_W-1:0] load_addr_i = '0;
  logic [7:0]        load_data_i = '0;
  logic              load_busy_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_en_o;
  logic [7:0]        mem_rdata_i = '0;
  logic              mem_wr_en_o;
  logic [7:0]        mem_wdata_o;
  logic              fetch_fault_o;

  always #5 clk_i = ~clk_i;

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .instr_valid_o    (instr_valid_o),
    .instr_ready_i    (instr_ready_i),
    .instr_code_o     (instr_code_o),
    .instr_pc_o       (instr_pc_o),
    .load_req_i       (load_req_i),
    .load_valid_i     (load_valid_i),
    .load_addr_i      (load_addr_i),
    .load_data_i      (load_data_i),
    .load_busy_o      (load_busy_o),
    .mem_addr_o       (mem_addr_o),
    .mem_rd_en_o      (mem_rd_en_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_wr_en_o      (mem_wr_en_o),
    .mem_wdata_o      (mem_wdata_o),
    .fetch_fault_o    (fetch_fault_o)
  );

  // Physical memory driven by the DUT; ref_mem is the model's own view of its contents.
  logic [7:0] phys_mem [MEM_SZ];
  logic [7:0] ref_mem  [MEM_SZ];

  always @(posedge clk_i) begin
    if (mem_wr_en_o) phys_mem[mem_addr_o] <= mem_wdata_o;
    if (mem_rd_en_o) mem_rdata_i <= phys_mem[mem_addr_o];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: where in the fetch timeline we are, not how the RTL counts.
  typedef enum {M_FETCH, M_HOLD, M_LOAD} mmode_e;
  mmode_e      m_mode  = M_FETCH;
  int          m_fcyc  = 0;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_code  = '0;
  logic [31:0] m_ipc   = RESET_PC;
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_fault = 1'b0;
  bit          m_ok    = 1'b0;

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [31:0]       w;
    logic [ADDR_W-1:0] a;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      a = pc[ADDR_W-1:0] + ADDR_W'(i);
      w = {w[23:0], ref_mem[a]};
    end
    return w;
  endfunction

  always @(negedge clk_i) begin
    logic              exp_rd, exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    if (m_ok) begin
      exp_rd   = !rst_i && m_mode == M_FETCH && m_fcyc < 4;
      exp_wr   = !rst_i && m_mode == M_LOAD && load_valid_i;
      exp_addr = (m_mode == M_LOAD) ? load_addr_i : m_pc[ADDR_W-1:0] + ADDR_W'(m_fcyc);
      check("instr_valid", 32'(instr_valid_o), 32'(m_valid));
      check("load_busy", 32'(load_busy_o), 32'(m_busy));
      check("fetch_fault", 32'(fetch_fault_o), 32'(m_fault));
      check("mem_rd_en", 32'(mem_rd_en_o), 32'(exp_rd));
      check("mem_wr_en", 32'(mem_wr_en_o), 32'(exp_wr));
      if (exp_rd || exp_wr) check("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
      if (exp_wr) check("mem_wdata", 32'(mem_wdata_o), 32'(load_data_i));
      if (m_valid) begin
        check("instr_code", instr_code_o, m_code);
        check("instr_pc", instr_pc_o, m_ipc);
      end
    end
    // Advance the model with the inputs the DUT will sample at the next rising edge.
    if (rst_i) begin
      m_mode = M_FETCH; m_fcyc = 0; m_pc = RESET_PC; m_code = '0; m_ipc = RESET_PC;
      m_valid = 1'b0; m_busy = 1'b0; m_fault = 1'b0; m_ok = 1'b1;
    end else if (m_mode == M_LOAD) begin
      if (load_valid_i) ref_mem[load_addr_i] = load_data_i;
      if (!load_req_i) begin
        m_mode = M_FETCH; m_fcyc = 0; m_pc = RESET_PC; m_busy = 1'b0;
      end
    end else if (load_req_i) begin
      m_mode = M_LOAD; m_valid = 1'b0; m_busy = 1'b1;
    end else if (redirect_valid_i) begin
      m_valid = 1'b0;
      if (MISALIGN_CHK && redirect_pc_i[1:0] != 2'b00) begin
        m_fault = 1'b1; m_mode = M_HOLD;
      end else begin
        m_pc = redirect_pc_i; m_mode = M_FETCH; m_fcyc = 0;
      end
    end else if (m_mode == M_FETCH) begin
      if (m_fcyc == 4) begin
        m_valid = 1'b1; m_code = ref_word(m_pc); m_ipc = m_pc; m_mode = M_HOLD;
      end else begin
        m_fcyc++;
      end
    end else if (m_valid && instr_ready_i) begin
      m_valid = 1'b0; m_pc = m_pc + 32'd4; m_mode = M_FETCH; m_fcyc = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      if (instr_valid_o) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) check("wait_valid_timeout", 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    int          cyc;
    bit          ld_active;
    logic [7:0]  b;
    logic [7:0]  ld_bytes [4];
    logic [31:0] wrap_a [4];
    logic [31:0] wrap_b [4];

    ld_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    wrap_a   = '{32'd2044, 32'd2045, 32'd2046, 32'd2047};
    wrap_b   = '{32'd2047, 32'd0, 32'd1, 32'd2};
    for (int i = 0; i < MEM_SZ; i++) begin
      b = 8'($urandom);
      phys_mem[i] = b;
      ref_mem[i]  = b;
    end
    phys_mem[0] = 8'h00; phys_mem[1] = 8'h50; phys_mem[2] = 8'h00; phys_mem[3] = 8'h93;
    ref_mem[0]  = 8'h00; ref_mem[1]  = 8'h50; ref_mem[2]  = 8'h00; ref_mem[3]  = 8'h93;
    for (int i = 0; i < 4; i++) begin
      phys_mem['h40 + i] = 8'(8'h12 + 8'(i) * 8'h22);
      ref_mem['h40 + i]  = 8'(8'h12 + 8'(i) * 8'h22);
    end

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    check("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    check("rst_load_busy", 32'(load_busy_o), 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en_o), 32'd0);
    check("rst_mem_wr_en", 32'(mem_wr_en_o), 32'd0);
    check("rst_instr_code", instr_code_o, 32'h0);
    check("rst_instr_pc", instr_pc_o, RESET_PC);
    check("rst_fetch_fault", 32'(fetch_fault_o), 32'd0);
    tick();
    rst_i = 1'b0;

    // First fetch latency and word assembly
    wait_valid(cyc);
    check("first_latency", 32'(cyc), 32'd5);
    check("first_code", instr_code_o, 32'h00500093);
    check("first_pc", instr_pc_o, 32'h0);
    tick();
    instr_ready_i = 1'b0;

    // Back-pressure hold
    wait_valid(cyc);
    check("second_pc", instr_pc_o, 32'h4);
    repeat (10) tick();
    @(negedge clk_i);
    check("hold_pc", instr_pc_o, 32'h4);
    check("hold_valid", 32'(instr_valid_o), 32'd1);
    check("hold_rd_en", 32'(mem_rd_en_o), 32'd0);
    tick();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    wait_valid(cyc);
    check("third_pc", instr_pc_o, 32'h8);

    // Redirect together with an accept in HOLD
    tick();
    instr_ready_i    = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h40;
    tick();
    redirect_valid_i = 1'b0;
    wait_valid(cyc);
    check("redir_accept_pc", instr_pc_o, 32'h40);
    check("redir_accept_code", instr_code_o, 32'h12345678);

    // Redirect during issue k=2 of the fetch at 0x44
    tick();
    tick();
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h40;
    @(negedge clk_i);
    check("redir_k2_addr", 32'(mem_addr_o), 32'h46);
    tick();
    redirect_valid_i = 1'b0;
    wait_valid(cyc);
    check("redir_k2_pc", instr_pc_o, 32'h40);
    check("redir_k2_code", instr_code_o, 32'h12345678);

    // Load session started mid-fetch
    tick();
    tick();
    load_req_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      load_valid_i = 1'b1;
      load_addr_i  = ADDR_W'(i);
      load_data_i  = ld_bytes[i];
      if (i == 0) begin
        @(negedge clk_i);
        check("load_busy_on", 32'(load_busy_o), 32'd1);
        check("load_rd_en", 32'(mem_rd_en_o), 32'd0);
      end
      tick();
    end
    load_valid_i = 1'b0;
    load_req_i   = 1'b0;
    tick();
    @(negedge clk_i);
    check("load_busy_off", 32'(load_busy_o), 32'd0);
    wait_valid(cyc);
    check("load_code", instr_code_o, 32'hDEADBEEF);
    check("load_pc", instr_pc_o, RESET_PC);

    // Address wrap at the top of memory
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'd2044;
    tick();
    redirect_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("wrap_2044_addr", 32'(mem_addr_o), wrap_a[i]);
    end
`ifndef IFETCH_MISALIGN_CHK_EN
    wait_valid(cyc);
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'd2047;
    tick();
    redirect_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("wrap_2047_addr", 32'(mem_addr_o), wrap_b[i]);
    end
`else
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h6;
    tick();
    redirect_valid_i = 1'b0;
    @(negedge clk_i);
    check("misalign_fault", 32'(fetch_fault_o), 32'd1);
    check("misalign_valid", 32'(instr_valid_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("misalign_stall_rd", 32'(mem_rd_en_o), 32'd0);
    end
    tick();
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h0;
    tick();
    redirect_valid_i = 1'b0;
    check("wrap_2047_unused", wrap_b[0], 32'(mem_addr_o) | 32'd2047);
`endif

    // Randomized traffic
    ld_active = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst_i            = ($urandom_range(0, 499) == 0);
      instr_ready_i    = ($urandom_range(0, 3) != 0);
      redirect_valid_i = ($urandom_range(0, 24) == 0);
      redirect_pc_i    = $urandom;
      if ($urandom_range(0, 1) == 0) redirect_pc_i[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) redirect_pc_i[31:ADDR_W] = '0;
      load_valid_i = ($urandom_range(0, 2) == 0);
      load_addr_i  = ADDR_W'($urandom);
      load_data_i  = 8'($urandom);
      if (ld_active) begin
        if ($urandom_range(0, 9) == 0) ld_active = 1'b0;
      end else begin
        ld_active = ($urandom_range(0, 149) == 0);
      end
      load_req_i = ld_active;
    end
    tick();
    rst_i = 1'b0; redirect_valid_i = 1'b0; load_req_i = 1'b0; load_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
